// File: rtl/sample_framer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_framer_pkg : shared FSM state type and constants for sample_framer
// Rev 1.0
// ---------------------------------------------------------------------------
package sample_framer_pkg;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hC3C3;
  localparam int          SEQ_WIDTH         = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HEADER   = 3'd1,
    ST_PAYLOAD  = 3'd2,
    ST_CHECKSUM = 3'd3
`ifdef SAMPLE_FRAMER_SEQ_EN
    , ST_SEQ    = 3'd4
`endif
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_fifo : input sample buffer; head read is combinational, pushes while
// full are ignored. Rev 1.0
// ---------------------------------------------------------------------------
module sample_fifo
  import sample_framer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_WIDTH-1:0]       din,
  output logic [DATA_WIDTH-1:0]       dout,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_en, rd_en;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    wr_en    = push && !full;
    rd_en    = pop && !empty;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/sample_framer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_framer : buffers samples and emits header/payload/checksum frames.
// Optional sequence word enabled by SAMPLE_FRAMER_SEQ_EN. Rev 1.0
// ---------------------------------------------------------------------------
module sample_framer
  import sample_framer_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    FRAME_LEN  = 4,
  parameter int                    FIFO_DEPTH = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = DATA_WIDTH'(SYNC_WORD_DEFAULT)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        valid_in,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int            CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int            BW          = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);
  localparam logic [BW-1:0] LAST_BEAT   = BW'(FRAME_LEN - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  overflow_q, overflow_d;
`ifdef SAMPLE_FRAMER_SEQ_EN
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
`endif

  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full, fifo_empty, fifo_pop;

  sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (valid_in),
    .pop   (fifo_pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A sample arriving while full is lost even if a pop frees a slot this cycle.
  assign overflow_d = overflow_q | (valid_in & fifo_full);
  assign overflow   = overflow_q;

  always_comb begin
    state_d    = state_q;
    checksum_d = checksum_q;
    beat_d     = beat_q;
    fifo_pop   = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    m_data     = '0;
`ifdef SAMPLE_FRAMER_SEQ_EN
    seq_d      = seq_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fifo_count >= FRAME_LEN_C) begin
          state_d    = ST_HEADER;
          checksum_d = '0;
          beat_d     = '0;
        end
      end
      ST_HEADER: begin
        m_valid = 1'b1;
        m_data  = SYNC_WORD;
        if (m_ready) begin
`ifdef SAMPLE_FRAMER_SEQ_EN
          state_d = ST_SEQ;
`else
          state_d = ST_PAYLOAD;
`endif
        end
      end
`ifdef SAMPLE_FRAMER_SEQ_EN
      ST_SEQ: begin
        m_valid = 1'b1;
        m_data  = DATA_WIDTH'(seq_q);
        if (m_ready) state_d = ST_PAYLOAD;
      end
`endif
      ST_PAYLOAD: begin
        m_valid = 1'b1;
        m_data  = fifo_dout;
        if (m_ready && !fifo_empty) begin
          fifo_pop   = 1'b1;
          checksum_d = checksum_q + fifo_dout;
          beat_d     = beat_q + BW'(1);
          if (beat_q == LAST_BEAT) state_d = ST_CHECKSUM;
        end
      end
      ST_CHECKSUM: begin
        m_valid = 1'b1;
        m_last  = 1'b1;
        m_data  = checksum_q;
        if (m_ready) begin
          state_d = ST_IDLE;
`ifdef SAMPLE_FRAMER_SEQ_EN
          seq_d   = seq_q + SEQ_WIDTH'(1);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      checksum_q <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
`ifdef SAMPLE_FRAMER_SEQ_EN
      seq_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      checksum_q <= checksum_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
`ifdef SAMPLE_FRAMER_SEQ_EN
      seq_q      <= seq_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sample_framer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sample_framer : directed scoreboard bench for sample_framer. Rev 1.0
// ---------------------------------------------------------------------------
module tb_sample_framer;

  localparam logic [15:0] SYNC = 16'hC3C3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        overflow;
  logic [3:0]  fifo_count;

  sample_framer #(
    .DATA_WIDTH (16),
    .FRAME_LEN  (4),
    .FIFO_DEPTH (8),
    .SYNC_WORD  (SYNC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } word_t;

  word_t sb[$];
  word_t mon_e;
  int    checks = 0;
  int    errors = 0;
  int    exp_seq = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] held_data = '0;
  logic        held_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transfers are sampled on the falling edge, half a cycle before they happen.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(held_data));
        chk("stall_last", 32'(m_last), 32'(held_last));
      end
      if (m_valid && m_ready) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("word_data", 32'(m_data), 32'(mon_e.data));
          chk("word_last", 32'(m_last), 32'(mon_e.last));
        end
      end
      stall_prev = m_valid && !m_ready;
      held_data  = m_data;
      held_last  = m_last;
    end
  end

  task automatic send(input logic [15:0] d);
    valid_in = 1'b1;
    data_in  = d;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic expect_frame(input logic [15:0] a, b, c, d);
    logic [15:0] sum;
    sum = a + b + c + d;
    sb.push_back('{data: SYNC, last: 1'b0});
`ifdef SAMPLE_FRAMER_SEQ_EN
    sb.push_back('{data: 16'(exp_seq), last: 1'b0});
    exp_seq = (exp_seq + 1) % 256;
`endif
    sb.push_back('{data: a, last: 1'b0});
    sb.push_back('{data: b, last: 1'b0});
    sb.push_back('{data: c, last: 1'b0});
    sb.push_back('{data: d, last: 1'b0});
    sb.push_back('{data: sum, last: 1'b1});
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      if (m_valid) break;
      @(posedge clk); #1;
    end
    chk("wait_valid", 32'(m_valid), 32'd1);
  endtask

  task automatic drain(input logic [3:0] exp_count);
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !m_valid) break;
      @(posedge clk); #1;
    end
    chk("drain_done", 32'(sb.size()), 32'd0);
    chk("drain_idle", 32'(m_valid), 32'd0);
    chk("fifo_count_after", 32'(fifo_count), 32'(exp_count));
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    m_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    sb.delete();
    exp_seq  = 0;
  endtask

`ifdef SAMPLE_FRAMER_SEQ_EN
  localparam int PRE_PAYLOAD = 2;
`else
  localparam int PRE_PAYLOAD = 1;
`endif

  initial begin
    // Reset state
    do_reset();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);

    // Basic frame with latency check
    m_ready = 1'b1;
    expect_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0004);
    chk("lat_k1_idle", 32'(m_valid), 32'd0);
    chk("lat_k1_count", 32'(fifo_count), 32'd4);
    @(posedge clk); #1;
    chk("lat_k2_valid", 32'(m_valid), 32'd1);
    chk("lat_k2_sync", 32'(m_data), 32'(SYNC));
    drain(4'd0);
    chk("basic_overflow", 32'(overflow), 32'd0);

    // Checksum wrap
    expect_frame(16'hFFFF, 16'h0002, 16'h0000, 16'h0000);
    send(16'hFFFF); send(16'h0002); send(16'h0000); send(16'h0000);
    drain(4'd0);

    // Backpressure during payload
    m_ready = 1'b0;
    expect_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0004);
    wait_valid();
    chk("bp_header", 32'(m_data), 32'(SYNC));
    m_ready = 1'b1;
    repeat (PRE_PAYLOAD + 1) begin
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("bp_held_data", 32'(m_data), 32'h0002);
    m_ready = 1'b1;
    drain(4'd0);

    // Overflow: nine samples into an eight-deep FIFO while stalled
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(16'(16'h0011 + i));
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    expect_frame(16'h0011, 16'h0012, 16'h0013, 16'h0014);
    expect_frame(16'h0015, 16'h0016, 16'h0017, 16'h0018);
    m_ready = 1'b1;
    drain(4'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_reset();
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Reset mid-frame after two payload accepts
    sb.push_back('{data: SYNC, last: 1'b0});
`ifdef SAMPLE_FRAMER_SEQ_EN
    sb.push_back('{data: 16'h0000, last: 1'b0});
`endif
    sb.push_back('{data: 16'h0021, last: 1'b0});
    sb.push_back('{data: 16'h0022, last: 1'b0});
    send(16'h0021); send(16'h0022); send(16'h0023); send(16'h0024);
    send(16'h0025);
    wait_valid();
    m_ready = 1'b1;
    repeat (PRE_PAYLOAD + 2) begin
      @(posedge clk); #1;
    end
    chk("mid_partial_sent", 32'(sb.size()), 32'd0);
    m_ready = 1'b0;
    reset   = 1'b1;
    @(posedge clk); #1;
    reset   = 1'b0;
    exp_seq = 0;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    m_ready = 1'b1;
    expect_frame(16'h0031, 16'h0032, 16'h0033, 16'h0034);
    send(16'h0031); send(16'h0032); send(16'h0033); send(16'h0034);
    drain(4'd0);

    // Back-to-back frames with FIFO refill during output
    expect_frame(16'h1000, 16'h2000, 16'h3000, 16'h4000);
    expect_frame(16'h8000, 16'h8000, 16'h0001, 16'h0002);
    send(16'h1000); send(16'h2000); send(16'h3000); send(16'h4000);
    send(16'h8000); send(16'h8000); send(16'h0001); send(16'h0002);
    drain(4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sample_framer.md
Name: sample_framer

Overview:
- Sits directly downstream of the pipelined sensor data-transfer stage and consumes its processed_data/valid_out stream.
- The upstream stage has no backpressure, so samples are buffered in a small FIFO.
- Once a full frame is buffered, it emits a ready/valid frame: sync header, FRAME_LEN payload samples, then a wrapping-sum checksum word with m_last.
- Feeds the link/transport layer.

Parameters:
- DATA_WIDTH, 16, sample and output word width.
- FRAME_LEN, 4, payload samples per frame; must be ≥1 and ≤ FIFO_DEPTH.
- FIFO_DEPTH, 8, input buffer entries; power of two.
- SYNC_WORD, 16'hC3C3, header word; sized to DATA_WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  sample from the upstream processed_data.
- valid_in  in  1  sample-valid strobe from the upstream valid_out; no ready is returned.
- m_data  out  DATA_WIDTH  output frame word.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts; a transfer occurs when m_valid && m_ready.
- m_last  out  1  high with the checksum word only.
- overflow  out  1  sticky; a sample was dropped.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high, on clk):
  - FIFO is emptied; fifo_count=0.
  - State goes to IDLE; checksum=0.
  - m_valid=0, m_last=0, m_data=0, overflow=0.
  - Reset mid-frame abandons the frame. No partial frame or m_last follows.
- FIFO push:
  - A sample is written when valid_in=1 and fifo_count<FIFO_DEPTH.
  - If valid_in=1 while full, the sample is dropped and overflow is set. This holds even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, HEADER, PAYLOAD, CHECKSUM (plus SEQ with the optional feature).
  - IDLE: m_valid=0. Moves to HEADER when the registered fifo_count ≥ FRAME_LEN. Checksum and payload counter are cleared on this transition.
  - HEADER: m_data=SYNC_WORD, m_valid=1. Moves on to PAYLOAD when the word is accepted.
  - PAYLOAD: m_data=FIFO head, m_valid=1.
    - Each accept pops one sample, adds it to the checksum, and increments the payload counter.
    - After FRAME_LEN accepts, moves to CHECKSUM.
    - The FIFO cannot underflow here, because entry required FRAME_LEN samples already buffered.
  - CHECKSUM: m_data = checksum (sum of the payload words mod 2^DATA_WIDTH), m_valid=1, m_last=1. On accept, returns to IDLE.
  - Back-to-back frames: if the FIFO still holds ≥ FRAME_LEN samples, HEADER follows after exactly one IDLE cycle.
- Output stability: while m_valid=1 and m_ready=0, m_data and m_last are held stable.
- Latency: if the FRAME_LEN-th sample has valid_in=1 in cycle k, the header has m_valid=1 in cycle k+2. With m_ready held at 1, the frame occupies FRAME_LEN+2 consecutive cycles.
- Samples keep being accepted into the FIFO throughout frame output.

Optional Feature:
- Macro: SAMPLE_FRAMER_SEQ_EN.
- Defined:
  - A SEQ state sits between HEADER and PAYLOAD and emits an 8-bit frame sequence number, zero-extended to DATA_WIDTH.
  - The number is 0 after reset and increments on each checksum accept, wrapping 255→0.
  - It is not included in the checksum.
  - A frame is then FRAME_LEN+3 words.
- Undefined: no SEQ state and no sequence counter logic.

Decomposition:
- Package sample_framer_pkg holds:
  - the FSM state enum;
  - the default SYNC_WORD constant;
  - the sequence-number width constant (8).
- One sub-module, sample_fifo (parameters DATA_WIDTH, FIFO_DEPTH):
  - ports: push, pop, din, dout, count, full, empty;
  - combinational head read;
  - drop-on-full rule.
- The FSM, checksum and overflow logic stay in sample_framer.

Test Plan:
- Basic frame: FRAME_LEN=4, m_ready=1, samples 0001,0002,0003,0004 → C3C3,0001,0002,0003,0004,000A. m_last only on 000A; header appears 2 cycles after the last sample.
- Checksum wrap: payload FFFF,0002,0000,0000 → checksum 0001.
- Backpressure: m_ready toggled 1,0,0,1 during payload → no word lost or duplicated; m_data stable while stalled; same sequence as the basic frame.
- Overflow: m_ready=0 with 9 samples pushed (FIFO_DEPTH=8) → fifo_count=8 and overflow=1. Then m_ready=1 → two frames carry the first 8 samples; overflow stays 1 until reset.
- Reset mid-frame: reset asserted during PAYLOAD after 2 accepts → next cycle m_valid=0, fifo_count=0. Four new samples then produce a clean full frame.
- SEQ feature (SAMPLE_FRAMER_SEQ_EN): two consecutive frames → word 2 is 0000 then 0001; checksums unchanged from the non-SEQ case.
